vga_pattern_gen: RTL and testbench

Pixel-colour stage placed directly downstream of the VGA timing controller. Consumes its registered `hsync`, `vsync`, `video_on` and `horizontal_num`, tracks the active row internally, and drives 4-bit-per-channel RGB plus sync outputs delayed to stay aligned with the colour data. A debounced push-button steps through four test patterns; the pattern switch is deferred to a frame boundary to prevent tearing.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 51 +++++
 rtl/vga_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pattern generator: pattern modes,
// the RGB pixel payload and the 3-bit colour index decode.
package vga_pkg;

  localparam int unsigned HVID_DEF = 640;
  localparam int unsigned VVID_DEF = 480;
  localparam int unsigned CH_W     = 4;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    BARS     = 2'd1,
    CHECKER  = 2'd2,
    GRADIENT = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // idx[2] drives red, idx[1] green, idx[0] blue, each fully on or off
  function automatic rgb_t idx_to_rgb(input logic [2:0] idx);
    rgb_t c;
    c.r = idx[2] ? 4'hF : 4'h0;
    c.g = idx[1] ? 4'hF : 4'h0;
    c.b = idx[0] ? 4'hF : 4'h0;
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // Level flips only after the synchronised input has differed for the full window
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage behind the VGA timing controller: four test patterns,
// button-stepped at frame boundaries, with syncs re-registered alongside RGB.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned HVID            = HVID_DEF,
  parameter int unsigned VVID            = VVID_DEF,
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_25,
  input  logic       n_rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on_in,
  input  logic [9:0] horizontal_num,
  input  logic       mode_btn,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick
);

  localparam int unsigned ROW_W = 10;
  localparam int unsigned FC_W  = $clog2(FRAMES_PER_STEP + 1);
  localparam int unsigned BAR_W = HVID / 8;

  logic              vsync_prev_q, von_prev_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              pending_q, pending_d;
  pattern_mode_t     mode_q, mode_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        bar;
  rgb_t              pix_q, pix_d;
  logic              hs_q, vs_q, ftick_q;
  logic              frame_edge;
  logic              btn_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk_25),
    .rst_n (n_rst),
    .btn_i (mode_btn),
    .rise_o(btn_rise)
  );

  assign frame_edge = vsync_in & ~vsync_prev_q;

  // Row tracking, step bookkeeping and mode sequencing
  always_comb begin
    row_d     = row_q;
    pending_d = pending_q | btn_rise;
    mode_d    = mode_q;
    fcnt_d    = fcnt_q;
    idx_d     = idx_q;
    if (vsync_in) begin
      row_d = '0;
    end else if (von_prev_q && !video_on_in && (row_q != ROW_W'(VVID - 1))) begin
      row_d = row_q + ROW_W'(1);
    end
    if (frame_edge) begin
      // A press landing on the edge itself waits for the next frame
      pending_d = btn_rise;
      if (pending_q) begin
        case (mode_q)
          SOLID:    mode_d = BARS;
          BARS:     mode_d = CHECKER;
          CHECKER:  mode_d = GRADIENT;
          GRADIENT: mode_d = SOLID;
          default:  mode_d = SOLID;
        endcase
      end
      if (fcnt_q == FC_W'(FRAMES_PER_STEP - 1)) begin
        fcnt_d = '0;
        idx_d  = idx_q + 3'd1;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  // Bar number by threshold comparison
  always_comb begin
    bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (horizontal_num >= 10'(k * BAR_W)) begin
        bar = 3'(k);
      end
    end
  end

  always_comb begin
    pix_d = '0;
    if (video_on_in) begin
      case (mode_q)
        SOLID:    pix_d = idx_to_rgb(idx_q);
        BARS:     pix_d = idx_to_rgb(3'd7 - bar);
        CHECKER:  pix_d = idx_to_rgb({3{horizontal_num[5] ^ row_q[5]}});
        GRADIENT: begin
          pix_d.r = horizontal_num[9:6];
          pix_d.g = row_q[8:5];
          pix_d.b = 4'h0;
        end
        default:  pix_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      vsync_prev_q <= 1'b0;
      von_prev_q   <= 1'b0;
      row_q        <= '0;
      pending_q    <= 1'b0;
      mode_q       <= SOLID;
      fcnt_q       <= '0;
      idx_q        <= 3'd0;
      pix_q        <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      ftick_q      <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_in;
      von_prev_q   <= video_on_in;
      row_q        <= row_d;
      pending_q    <= pending_d;
      mode_q       <= mode_d;
      fcnt_q       <= fcnt_d;
      idx_q        <= idx_d;
      pix_q        <= pix_d;
      hs_q         <= hsync_in;
      vs_q         <= vsync_in;
      ftick_q      <= frame_edge;
    end
  end

  assign red        = pix_q.r;
  assign green      = pix_q.g;
  assign blue       = pix_q.b;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign frame_tick = ftick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised frame-level bench for vga_pattern_gen against a pattern-rule
// reference model (short lines, full-width column values).
module tb_vga_pattern_gen;

  localparam int HVID  = 640;
  localparam int VVID  = 48;
  localparam int FPS   = 2;
  localparam int DEB   = 16;
  localparam int ACT   = 8;
  localparam int LINE  = 12;
  localparam int NLINE = VVID + 3;

  logic       clk_25;
  logic       n_rst;
  logic       hsync_in, vsync_in, video_on_in, mode_btn;
  logic [9:0] horizontal_num;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, frame_tick;

  vga_pattern_gen #(
    .HVID(HVID), .VVID(VVID), .FRAMES_PER_STEP(FPS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_25(clk_25), .n_rst(n_rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on_in(video_on_in), .horizontal_num(horizontal_num), .mode_btn(mode_btn),
    .red(red), .green(green), .blue(blue), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_tick(frame_tick)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  int n_checks;
  int n_fail;

  // Reference state: mode number, frame edges seen, pending step
  int          m_mode;
  int          m_edges;
  bit          m_pending;
  bit          prev_vs;
  bit          exp_valid;
  logic [11:0] exp_rgb;
  bit          exp_hs, exp_vs, exp_ft;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pixel(input int mode, input int idx, input int x,
                                            input int row, input bit von);
    int c;
    if (!von) return 12'h000;
    case (mode)
      0:       c = idx;
      1:       c = 7 - x / (HVID / 8);
      2:       c = (((x / 32) % 2) != ((row / 32) % 2)) ? 7 : 0;
      default: return {4'((x / 64) % 16), 4'((row / 32) % 16), 4'h0};
    endcase
    return {4'(((c / 4) % 2) * 15), 4'(((c / 2) % 2) * 15), 4'((c % 2) * 15)};
  endfunction

  function automatic int pix_x(input int p);
    case (p)
      0:       return 0;
      1:       return 80;
      2:       return 639;
      3:       return 32;
      4:       return 79;
      default: return int'($urandom_range(639));
    endcase
  endfunction

  // One pixel clock: check last cycle's outputs, then apply new inputs
  task automatic cyc(input bit hs, input bit vs, input bit von, input int x, input int row);
    @(negedge clk_25);
    if (exp_valid) begin
      check_eq("rgb", 32'({red, green, blue}), 32'(exp_rgb));
      check_eq("hsync_out", 32'(hsync_out), 32'(exp_hs));
      check_eq("vsync_out", 32'(vsync_out), 32'(exp_vs));
      check_eq("frame_tick", 32'(frame_tick), 32'(exp_ft));
    end
    hsync_in       = hs;
    vsync_in       = vs;
    video_on_in    = von;
    horizontal_num = 10'(x);
    exp_rgb   = ref_pixel(m_mode, (m_edges / FPS) % 8, x, row, von);
    exp_hs    = hs;
    exp_vs    = vs;
    exp_ft    = vs && !prev_vs;
    exp_valid = 1'b1;
    if (vs && !prev_vs) begin
      m_edges++;
      if (m_pending) begin
        m_mode    = (m_mode + 1) % 4;
        m_pending = 1'b0;
      end
    end
    prev_vs = vs;
  endtask

  task automatic line(input bit vs, input bit act, input int row);
    for (int p = 0; p < LINE; p++) begin
      if (act && p < ACT) cyc(1'b0, vs, 1'b1, pix_x(p), row);
      else cyc((p == ACT + 1) || (p == ACT + 2), vs, 1'b0, 640 + int'($urandom_range(150)), row);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk_25);
    n_rst = 1'b0;
    #1;
    check_eq("rst_rgb", 32'({red, green, blue}), 32'h0);
    check_eq("rst_hsync", 32'(hsync_out), 32'h0);
    check_eq("rst_vsync", 32'(vsync_out), 32'h0);
    check_eq("rst_tick", 32'(frame_tick), 32'h0);
    hsync_in = 1'b0; vsync_in = 1'b0; video_on_in = 1'b0; horizontal_num = '0;
    repeat (3) @(negedge clk_25);
    n_rst     = 1'b1;
    m_mode    = 0;
    m_edges   = 0;
    m_pending = 1'b0;
    prev_vs   = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Line 0 carries vsync, line 1 is blank, then VVID active rows, then one blank line
  task automatic frame(input int rst_line);
    bit vs;
    bit act;
    int row;
    for (int l = 0; l < NLINE; l++) begin
      vs  = (l == 0);
      act = (l >= 2) && (l < 2 + VVID);
      row = act ? l - 2 : 0;
      if (l == rst_line) begin
        for (int p = 0; p < 3; p++) cyc(1'b0, 1'b0, 1'b1, pix_x(p), row);
        mid_reset();
        return;
      end
      line(vs, act, row);
    end
  endtask

  task automatic press(input int hold, input bit valid);
    @(negedge clk_25);
    mode_btn = 1'b1;
    repeat (hold) @(negedge clk_25);
    mode_btn = 1'b0;
    repeat (24) @(negedge clk_25);
    if (valid) m_pending = 1'b1;
  endtask

  // Runs a frame with button activity starting around active row 5
  task automatic frame_with_presses(input int n_press, input int hold);
    fork
      frame(-1);
      begin
        repeat (84) @(negedge clk_25);
        for (int i = 0; i < n_press; i++) press(hold, hold >= 20);
      end
    join
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_mode = 0; m_edges = 0; m_pending = 1'b0; prev_vs = 1'b0; exp_valid = 1'b0;
    exp_rgb = '0; exp_hs = 1'b0; exp_vs = 1'b0; exp_ft = 1'b0;
    n_rst = 1'b0; mode_btn = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b1; horizontal_num = '0;
    repeat (4) @(negedge clk_25);
    check_eq("reset_rgb", 32'({red, green, blue}), 32'h0);
    check_eq("reset_hsync", 32'(hsync_out), 32'h0);
    check_eq("reset_vsync", 32'(vsync_out), 32'h0);
    check_eq("reset_tick", 32'(frame_tick), 32'h0);
    hsync_in = 1'b0; vsync_in = 1'b0; video_on_in = 1'b0;
    @(negedge clk_25);
    n_rst = 1'b1;

    frame(-1);                   // SOLID idx 0
    frame(-1);                   // SOLID idx 1
    frame_with_presses(1, 8);    // short glitch: no step
    frame_with_presses(1, 20);   // still SOLID, step latched
    frame_with_presses(3, 20);   // BARS; three presses give one step
    frame(-1);                   // CHECKER
    frame_with_presses(1, 20);   // CHECKER, step latched
    frame_with_presses(1, 20);   // GRADIENT, step back to SOLID
    for (int f = 0; f < 8; f++) frame(-1);  // SOLID through index wrap
    frame_with_presses(1, 20);
    frame(12);                   // BARS, reset during row 10

    frame(-1);                   // SOLID idx 0 after reset
    frame_with_presses(1, 20);
    frame(-1);                   // BARS after reset
    cyc(1'b0, 1'b0, 1'b0, 700, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
